irq_controller: RTL and testbench

//  Interrupt arbiter between the external IRQ sources and csr_controller/core trap path.

---
 rtl/irq_controller.sv | 120 ++++++++++++
 tb/tb_irq_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Fixed-priority interrupt arbiter with exception nesting and
//               mret acknowledge back to the serviced request line.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int          N_IRQ      = 16,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             exception_i,
    input  logic             mret_i,
    input  logic [31:0]      mie_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ret_o,
    output logic             busy_o
);

    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRQ  = 2'd1,
        ST_EXC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    state_t             prev_q,  prev_d;
    logic               irq_q,   irq_d;
    logic [31:0]        cause_q, cause_d;
    logic [N_IRQ-1:0]   ret_q,   ret_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic               block_q, block_d;

    logic [N_IRQ-1:0]   w_masked;
    logic [ID_W-1:0]    w_sel;
    logic               w_unused_mie;

    assign w_masked     = irq_req_i & mie_i[16 +: N_IRQ];
    assign w_unused_mie = ^mie_i;

    // Descending scan so the lowest-numbered active line wins.
    always_comb begin
        w_sel = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (w_masked[k]) w_sel = ID_W'(k);
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        irq_d   = 1'b0;
        cause_d = cause_q;
        ret_d   = '0;
        id_d    = id_q;
        block_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exception_i) begin
                    state_d = ST_EXC;
                    prev_d  = ST_IDLE;
                end else if ((|w_masked) && !block_q) begin
                    state_d = ST_IRQ;
                    irq_d   = 1'b1;
                    cause_d = CAUSE_BASE + 32'(w_sel);
                    id_d    = w_sel;
                end
            end
            ST_IRQ: begin
                if (exception_i) begin
                    state_d = ST_EXC;
                    prev_d  = ST_IRQ;
                end else if (mret_i) begin
                    state_d = ST_IDLE;
                    block_d = 1'b1;
                    for (int k = 0; k < N_IRQ; k++) begin
                        ret_d[k] = (id_q == ID_W'(k));
                    end
                end
            end
            ST_EXC: begin
                if (!exception_i && mret_i) state_d = prev_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            prev_q  <= ST_IDLE;
            irq_q   <= 1'b0;
            cause_q <= '0;
            ret_q   <= '0;
            id_q    <= '0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            irq_q   <= irq_d;
            cause_q <= cause_d;
            ret_q   <= ret_d;
            id_q    <= id_d;
            block_q <= block_d;
        end
    end

    assign irq_o       = irq_q;
    assign irq_cause_o = cause_q;
    assign irq_ret_o   = ret_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exception_i = 1'b0;
    logic        mret_i = 1'b0;
    logic [31:0] mie_i = '0;
    logic [15:0] irq_req_i = '0;
    logic        irq_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ret_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    irq_controller #(.N_IRQ(16), .CAUSE_BASE(32'h8000_0010)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .exception_i (exception_i),
        .mret_i      (mret_i),
        .mie_i       (mie_i),
        .irq_req_i   (irq_req_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ret_o   (irq_ret_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq: got %0b want 0", irq_o); end
        checks++; if (irq_cause_o !== 32'h0) begin errors++; $display("FAIL rst_cause: got %h want 00000000", irq_cause_o); end
        checks++; if (irq_ret_o !== 16'h0) begin errors++; $display("FAIL rst_ret: got %h want 0000", irq_ret_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy_o); end
        rst = 1'b0;
        mret_i = 1'b1;   // mret in IDLE must be ignored
        step();
        mret_i = 1'b0;
        checks++; if (irq_ret_o !== 16'h0) begin errors++; $display("FAIL idle_mret_ret: got %h want 0000", irq_ret_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_mret_busy: got %0b want 0", busy_o); end
    endtask

    task automatic test_single();
        mie_i = 32'h0001_0000; irq_req_i = 16'h0001;
        step();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL t1_irq: got %0b want 1", irq_o); end
        checks++; if (irq_cause_o !== 32'h8000_0010) begin errors++; $display("FAIL t1_cause: got %h want 80000010", irq_cause_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy: got %0b want 1", busy_o); end
        step();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL t1_irq_pulse: got %0b want 0", irq_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_hold: got %0b want 1", busy_o); end
        irq_req_i = 16'h0; mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++; if (irq_ret_o !== 16'h0001) begin errors++; $display("FAIL t1_ret: got %h want 0001", irq_ret_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t1_busy_end: got %0b want 0", busy_o); end
        step();
        checks++; if (irq_ret_o !== 16'h0) begin errors++; $display("FAIL t1_ret_pulse: got %h want 0000", irq_ret_o); end
    endtask

    task automatic test_priority();
        irq_req_i = 16'h0006; mie_i = 32'h0004_0000;
        step();
        checks++; if (irq_cause_o !== 32'h8000_0012) begin errors++; $display("FAIL t2_cause_l2: got %h want 80000012", irq_cause_o); end
        irq_req_i = 16'h0; mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++; if (irq_ret_o !== 16'h0004) begin errors++; $display("FAIL t2_ret_l2: got %h want 0004", irq_ret_o); end
        step();
        irq_req_i = 16'h0006; mie_i = 32'h0006_0000;
        step();
        checks++; if (irq_cause_o !== 32'h8000_0011) begin errors++; $display("FAIL t2_cause_l1: got %h want 80000011", irq_cause_o); end
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL t2_irq_l1: got %0b want 1", irq_o); end
        irq_req_i = 16'h0; mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++; if (irq_ret_o !== 16'h0002) begin errors++; $display("FAIL t2_ret_l1: got %h want 0002", irq_ret_o); end
        step();
    endtask

    task automatic test_back_to_back();
        mie_i = 32'h0008_0000; irq_req_i = 16'h0008;
        step();
        checks++; if (irq_cause_o !== 32'h8000_0013) begin errors++; $display("FAIL t3_cause: got %h want 80000013", irq_cause_o); end
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++; if (irq_ret_o !== 16'h0008) begin errors++; $display("FAIL t3_ret: got %h want 0008", irq_ret_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t3_busy: got %0b want 0", busy_o); end
        step();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL t3_blocked: got %0b want 0", irq_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t3_blocked_busy: got %0b want 0", busy_o); end
        step();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL t3_retake: got %0b want 1", irq_o); end
        irq_req_i = 16'h0; mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        step();
    endtask

    task automatic test_exc_nest();
        mie_i = 32'h0001_0000; irq_req_i = 16'h0001;
        step();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL t4_irq: got %0b want 1", irq_o); end
        irq_req_i = 16'h0; exception_i = 1'b1;
        step();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t4_exc_busy: got %0b want 1", busy_o); end
        mret_i = 1'b1;   // exception and mret together: exception wins, stay in EXC
        step();
        exception_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t4_exc_both: got %0b want 1", busy_o); end
        step();
        checks++; if (irq_ret_o !== 16'h0) begin errors++; $display("FAIL t4_ret_exc: got %h want 0000", irq_ret_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t4_back_irq: got %0b want 1", busy_o); end
        checks++; if (irq_cause_o !== 32'h8000_0010) begin errors++; $display("FAIL t4_cause_held: got %h want 80000010", irq_cause_o); end
        step();
        mret_i = 1'b0;
        checks++; if (irq_ret_o !== 16'h0001) begin errors++; $display("FAIL t4_ret: got %h want 0001", irq_ret_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t4_idle: got %0b want 0", busy_o); end
        step();
    endtask

    task automatic test_exc_first();
        mie_i = 32'h0001_0000; irq_req_i = 16'h0001; exception_i = 1'b1;
        step();
        exception_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL t5_no_irq: got %0b want 0", irq_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t5_busy: got %0b want 1", busy_o); end
        mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t5_idle: got %0b want 0", busy_o); end
        checks++; if (irq_ret_o !== 16'h0) begin errors++; $display("FAIL t5_no_ret: got %h want 0000", irq_ret_o); end
        step();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL t5_irq: got %0b want 1", irq_o); end
        checks++; if (irq_cause_o !== 32'h8000_0010) begin errors++; $display("FAIL t5_cause: got %h want 80000010", irq_cause_o); end
        irq_req_i = 16'h0; mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        mie_i = 32'h0001_0000; irq_req_i = 16'h0001;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t6_busy: got %0b want 0", busy_o); end
        checks++; if (irq_cause_o !== 32'h0) begin errors++; $display("FAIL t6_cause: got %h want 00000000", irq_cause_o); end
        @(negedge clk);
        rst = 1'b0; irq_req_i = 16'h0; mret_i = 1'b1;
        step();
        mret_i = 1'b0;
        checks++; if (irq_ret_o !== 16'h0) begin errors++; $display("FAIL t6_no_ack: got %h want 0000", irq_ret_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t6_idle: got %0b want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_exc_nest();
        test_exc_first();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog: got timeout want completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
